// File: rtl/inst_rom_if.sv
// inst_rom_if: fetch request/response bundle between PC register, instruction ROM and IF/ID
interface inst_rom_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              stall;
  logic              addr_err;
  modport master (output ce, addr, inst_ready, input inst, inst_valid, stall, addr_err);
  modport slave (input ce, addr, inst_ready, output inst, inst_valid, stall, addr_err);
endinterface

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction ROM responder with wait states, valid/ready response and PC stall.
module inst_rom_resp #(
  parameter int    ADDR_W      = 32,
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic        clk,
  input logic        rst,
  inst_rom_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic [DEPTH_LOG2-1:0] idx_q, idx_nx, rd_idx;
  logic                  oor_q, oor_nx, oor_in, rd_oor;
  logic [DATA_W-1:0]     inst_q;
  logic                  err_q, stall, accept, load;
  logic [DATA_W-1:0]     rom [2**DEPTH_LOG2];
  initial rom = '{default: '0};
`ifdef INST_ROM_ADDR_CHECK_EN
  assign oor_in = |bus.addr[ADDR_W-1:DEPTH_LOG2];
`else
  logic unused_hi;
  assign oor_in    = 1'b0;
  assign unused_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2];
`endif
  assign stall  = state == WAIT || (state == RESP && !bus.inst_ready);
  assign accept = bus.ce && !stall;
  assign load   = WAIT_CYCLES == 0 ? accept : (state == WAIT && cnt == '0);
  assign rd_idx = state == WAIT ? idx_q : bus.addr[DEPTH_LOG2-1:0];
  assign rd_oor = state == WAIT ? oor_q : oor_in;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx_q;
    oor_nx   = oor_q;
    if (state == WAIT) begin
      cnt_nx   = cnt - 4'd1;
      state_nx = cnt == '0 ? RESP : WAIT;
    end else if (state == RESP && bus.inst_ready)
      state_nx = IDLE;
    if (accept) begin
      state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_nx   = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
      idx_nx   = bus.addr[DEPTH_LOG2-1:0];
      oor_nx   = oor_in;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      oor_q  <= 1'b0;
      inst_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx_q <= idx_nx;
      oor_q <= oor_nx;
      if (load) begin
        inst_q <= rd_oor ? '0 : rom[rd_idx];
        err_q  <= rd_oor;
      end
    end
  assign bus.inst       = inst_q;
  assign bus.inst_valid = state == RESP;
  assign bus.addr_err   = err_q;
  assign bus.stall      = stall;
endmodule

// File: tb/tb_inst_rom_resp.sv
// tb_inst_rom_resp: runs a zero-wait and a two-wait responder side by side against a latency-based reference model.
module tb_inst_rom_resp;
  localparam int AW = 32, DW = 32, DL = 10, WT = 2;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, ready = 1'b0;
  logic [AW-1:0] addr = '0;
  always #5 clk = ~clk;
  inst_rom_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  inst_rom_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  assign b0.ce = ce;
  assign b0.addr = addr;
  assign b0.inst_ready = ready;
  assign b1.ce = ce;
  assign b1.addr = addr;
  assign b1.inst_ready = ready;
  inst_rom_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  inst_rom_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(WT)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  logic [DW-1:0] o_inst [2];
  logic          o_v [2], o_s [2], o_e [2];
  assign o_inst[0] = b0.inst;
  assign o_inst[1] = b1.inst;
  assign o_v[0] = b0.inst_valid;
  assign o_v[1] = b1.inst_valid;
  assign o_s[0] = b0.stall;
  assign o_s[1] = b1.stall;
  assign o_e[0] = b0.addr_err;
  assign o_e[1] = b1.addr_err;
  logic [DW-1:0] rom_m [2**DL];
  bit            busy [2];
  int            due [2];
  logic [DW-1:0] m_inst [2];
  logic          m_err [2];
  int            cyc = 0, total = 0, passes = 0;
  bit            after_rst = 1'b0;
  function automatic logic [DW:0] ref_word(logic [AW-1:0] a);
`ifdef INST_ROM_ADDR_CHECK_EN
    if (a >= AW'(2**DL)) return {1'b1, {DW{1'b0}}};
`endif
    return {1'b0, rom_m[a[DL-1:0]]};
  endfunction
  task automatic chk(string tag, int k, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    if (obs === exp) passes++;
    else $display("FAIL %s[%0d] got %h want %h (cycle %0d)", tag, k, obs, exp, cyc);
  endtask
  task automatic cycle();
    bit v [2], acc [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      v[k] = busy[k] && cyc >= due[k];
      acc[k] = ce && !(busy[k] && !(v[k] && ready));
      chk("valid", k, DW'(o_v[k]), DW'(v[k]));
      chk("stall", k, DW'(o_s[k]), DW'(busy[k] && !(v[k] && ready)));
      if (v[k] || after_rst) begin
        chk("inst", k, o_inst[k], m_inst[k]);
        chk("addr_err", k, DW'(o_e[k]), DW'(m_err[k]));
      end
    end
    @(posedge clk);
    cyc++;
    after_rst = rst;
    for (int k = 0; k < 2; k++)
      if (rst) begin
        busy[k] = 1'b0;
        m_inst[k] = '0;
        m_err[k] = 1'b0;
      end else begin
        if (v[k] && ready) busy[k] = 1'b0;
        if (acc[k]) begin
          busy[k] = 1'b1;
          due[k] = cyc + (k == 1 ? WT : 0);
          {m_err[k], m_inst[k]} = ref_word(addr);
        end
      end
    @(negedge clk);
  endtask
  task automatic drive(logic r, logic c, logic rd, logic [AW-1:0] a, int n);
    rst = r; ce = c; ready = rd; addr = a;
    for (int i = 0; i < n; i++) cycle();
  endtask
  initial begin
    #2;
    for (int i = 0; i < 2**DL; i++) begin
      rom_m[i] = $urandom | 32'h1;
      dut0.rom[i] = rom_m[i];
      dut1.rom[i] = rom_m[i];
    end
    rst = 1'b1; ce = 1'b1;
    @(posedge clk);
    cyc++;
    after_rst = 1'b1;
    @(negedge clk);
    drive(1, 1, 1, 32'd3, 2);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, AW'(i), 1);
    drive(0, 0, 1, '0, 4);
    drive(0, 1, 1, 32'd7, 1);
    drive(0, 1, 0, 32'd9, 6);
    drive(0, 1, 1, 32'd11, 1);
    drive(0, 0, 1, '0, 4);
    drive(0, 1, 1, 32'h400, 1);
    drive(0, 0, 1, '0, 4);
    drive(0, 1, 1, 32'h7ff, 1);
    drive(0, 0, 1, '0, 4);
    drive(0, 1, 1, 32'd5, 1);
    drive(1, 0, 1, '0, 2);
    drive(0, 0, 1, '0, 6);
    drive(0, 1, 1, 32'd5, 1);
    drive(0, 0, 1, '0, 5);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0 ? AW'($urandom) : AW'($urandom_range(0, 2**DL - 1)), 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
